// File: rtl/rggen_apb_register_access_adapter.sv
// APB4 slave front end for the register/bit-field array: one APB transfer becomes
// at most one request/ready register access, with window check and access timeout.
module rggen_apb_register_access_adapter #(
  parameter int                         ADDRESS_WIDTH  = 16,
  parameter int                         BUS_WIDTH      = 32,
  parameter logic [ADDRESS_WIDTH-1:0]   BASE_ADDRESS   = '0,
  parameter int                         WINDOW_SIZE    = 256,
  parameter int                         TIMEOUT_CYCLES = 16
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_psel,
  input  logic                         i_penable,
  input  logic [ADDRESS_WIDTH-1:0]     i_paddr,
  input  logic                         i_pwrite,
  input  logic [BUS_WIDTH-1:0]         i_pwdata,
  input  logic [BUS_WIDTH/8-1:0]       i_pstrb,
  output logic                         o_pready,
  output logic [BUS_WIDTH-1:0]         o_prdata,
  output logic                         o_pslverr,
  output logic                         o_reg_valid,
  output logic                         o_reg_write,
  output logic [ADDRESS_WIDTH-1:0]     o_reg_address,
  output logic [BUS_WIDTH-1:0]         o_reg_write_data,
  output logic [BUS_WIDTH-1:0]         o_reg_write_mask,
  input  logic                         i_reg_ready,
  input  logic [BUS_WIDTH-1:0]         i_reg_read_data,
  input  logic [1:0]                   i_reg_status
);

  localparam int STRB_WIDTH = BUS_WIDTH / 8;
  localparam logic [ADDRESS_WIDTH-1:0] WORD_MASK =
    ~(ADDRESS_WIDTH'(STRB_WIDTH) - ADDRESS_WIDTH'(1));
  localparam logic [ADDRESS_WIDTH-1:0] WINDOW_MASK =
    ~(ADDRESS_WIDTH'(WINDOW_SIZE) - ADDRESS_WIDTH'(1));
  localparam int CNT_WIDTH = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST =
    CNT_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } state_e;

  state_e                     state_q, state_d;
  logic                       write_q, write_d;
  logic [ADDRESS_WIDTH-1:0]   addr_q, addr_d;
  logic [BUS_WIDTH-1:0]       wdata_q, wdata_d;
  logic [BUS_WIDTH-1:0]       wmask_q, wmask_d;
  logic [BUS_WIDTH-1:0]       rdata_q, rdata_d;
  logic                       err_q, err_d;
  logic [CNT_WIDTH-1:0]       count_q, count_d;

  logic                       setup;
  logic                       in_window;
  logic                       slave_err;
  logic [ADDRESS_WIDTH-1:0]   offset;
  logic [BUS_WIDTH-1:0]       strb_mask;
  logic                       in_access;
  logic                       in_respond;

  assign setup     = i_psel && !i_penable;
  // BASE_ADDRESS is window-aligned, so membership is a compare of the upper bits.
  assign in_window = (i_paddr & WINDOW_MASK) == BASE_ADDRESS;
  assign offset    = i_paddr - BASE_ADDRESS;
  assign slave_err = i_reg_status inside {2'b10, 2'b11};

  always_comb begin
    strb_mask = '0;
    for (int i = 0; i < STRB_WIDTH; i++) begin
      strb_mask[8*i +: 8] = {8{i_pstrb[i]}};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      count_q <= count_d;
    end
  end

  // Register handshake: the request is presented while o_reg_valid is high and is
  // held unchanged until the first cycle i_reg_ready is high; that cycle completes
  // the access and i_reg_read_data/i_reg_status are sampled with it.
  always_comb begin
    state_d = state_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (setup) begin
          write_d = i_pwrite;
          addr_d  = offset & WORD_MASK;
          wdata_d = i_pwrite ? i_pwdata : '0;
          wmask_d = i_pwrite ? strb_mask : '1;
          rdata_d = '0;
          count_d = '0;
          if (!in_window) begin
            err_d   = 1'b1;
            state_d = RESPOND;
          end else if (i_pwrite && (i_pstrb == '0)) begin
            err_d   = 1'b0;
            state_d = RESPOND;
          end else begin
            err_d   = 1'b0;
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (i_reg_ready) begin
          rdata_d = (!write_q && !slave_err) ? i_reg_read_data : '0;
          err_d   = slave_err;
          state_d = RESPOND;
        end else if ((TIMEOUT_CYCLES != 0) && (count_q == CNT_LAST)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESPOND;
        end else if (TIMEOUT_CYCLES != 0) begin
          count_d = count_q + CNT_WIDTH'(1);
        end
      end
      RESPOND: begin
        state_d = IDLE;
        count_d = '0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_access  = state_q == ACCESS;
  assign in_respond = state_q == RESPOND;

  // Outputs are gated by state so they read as zero outside their phase.
  assign o_reg_valid      = in_access;
  assign o_reg_write      = in_access && write_q;
  assign o_reg_address    = in_access ? addr_q  : '0;
  assign o_reg_write_data = in_access ? wdata_q : '0;
  assign o_reg_write_mask = in_access ? wmask_q : '0;

  assign o_pready  = in_respond;
  assign o_pslverr = in_respond && err_q;
  assign o_prdata  = in_respond ? rdata_q : '0;

endmodule

// File: tb/tb_rggen_apb_register_access_adapter.sv
// Bench for rggen_apb_register_access_adapter: directed and random APB transfers
// checked against a transaction-level model of the expected register access and response.
module tb_rggen_apb_register_access_adapter;

  localparam int AW      = 16;
  localparam int BW      = 32;
  localparam int BASE    = 0;
  localparam int WIN     = 256;
  localparam int TIMEOUT = 16;

  logic          clk;
  logic          rst_n;
  logic          psel;
  logic          penable;
  logic [AW-1:0] paddr;
  logic          pwrite;
  logic [BW-1:0] pwdata;
  logic [3:0]    pstrb;
  logic          pready;
  logic [BW-1:0] prdata;
  logic          pslverr;
  logic          reg_valid;
  logic          reg_write;
  logic [AW-1:0] reg_address;
  logic [BW-1:0] reg_write_data;
  logic [BW-1:0] reg_write_mask;
  logic          reg_ready;
  logic [BW-1:0] reg_read_data;
  logic [1:0]    reg_status;

  int n_tests = 0;
  int n_fail  = 0;
  logic [BW:0] exp_q[$];

  rggen_apb_register_access_adapter #(
    .ADDRESS_WIDTH  (AW),
    .BUS_WIDTH      (BW),
    .BASE_ADDRESS   (AW'(BASE)),
    .WINDOW_SIZE    (WIN),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_psel           (psel),
    .i_penable        (penable),
    .i_paddr          (paddr),
    .i_pwrite         (pwrite),
    .i_pwdata         (pwdata),
    .i_pstrb          (pstrb),
    .o_pready         (pready),
    .o_prdata         (prdata),
    .o_pslverr        (pslverr),
    .o_reg_valid      (reg_valid),
    .o_reg_write      (reg_write),
    .o_reg_address    (reg_address),
    .o_reg_write_data (reg_write_data),
    .o_reg_write_mask (reg_write_mask),
    .i_reg_ready      (reg_ready),
    .i_reg_read_data  (reg_read_data),
    .i_reg_status     (reg_status)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check_val({tag, "_pready"}, 64'(pready), 64'd0);
    check_val({tag, "_pslverr"}, 64'(pslverr), 64'd0);
    check_val({tag, "_prdata"}, 64'(prdata), 64'd0);
    check_val({tag, "_valid"}, 64'(reg_valid), 64'd0);
    check_val({tag, "_reg_fields"}, {reg_write, reg_address, reg_write_data != 0, reg_write_mask != 0}, 64'd0);
  endtask

  task automatic idle_cycles(input int n);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; reg_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_quiet("idle");
      if (i != n - 1) begin @(posedge clk); #1; end
    end
  endtask

  // One APB transfer; delay = ACCESS cycles without ready before ready is given.
  task automatic apb_xfer(input logic [AW-1:0] addr, input logic wr, input logic [BW-1:0] wdata,
                          input logic [3:0] strb, input int delay, input logic [BW-1:0] rdata,
                          input logic [1:0] status);
    logic          in_win, skip, tmo, err, got;
    int            exp_vcyc, vcyc;
    logic [BW-1:0] exp_mask, exp_wdata, exp_rd;
    logic [AW-1:0] exp_addr;
    logic [BW:0]   resp;
    // reference model
    in_win    = (int'(addr) >= BASE) && (int'(addr) < BASE + WIN);
    skip      = !in_win || (wr && strb == 4'd0);
    tmo       = !skip && (delay >= TIMEOUT);
    exp_vcyc  = skip ? 0 : (tmo ? TIMEOUT : delay + 1);
    err       = !in_win || tmo || (!skip && status >= 2'd2);
    exp_rd    = (!wr && !err) ? rdata : '0;
    exp_addr  = AW'(((int'(addr) - BASE) / 4) * 4);
    exp_wdata = wr ? wdata : '0;
    exp_mask  = '1;
    if (wr) begin
      for (int i = 0; i < 4; i++) exp_mask[8*i +: 8] = strb[i] ? 8'hFF : 8'h00;
    end
    exp_q.push_back({err, exp_rd});
    // setup phase
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = wdata; pstrb = strb;
    reg_ready = 1'b0;
    @(negedge clk);
    check_val("setup_pready", 64'(pready), 64'd0);
    @(posedge clk); #1;
    penable = 1'b1;
    vcyc = 0;
    got  = 1'b0;
    for (int cyc = 1; cyc <= 40 && !got; cyc++) begin
      reg_ready     = reg_valid && (vcyc == delay);
      reg_read_data = rdata;
      reg_status    = status;
      @(negedge clk);
      if (pready) begin
        got  = 1'b1;
        resp = exp_q.pop_front();
        check_val("latency", 64'(cyc), 64'(exp_vcyc + 1));
        check_val("pslverr", 64'(pslverr), 64'(resp[BW]));
        check_val("prdata", 64'(prdata), 64'(resp[BW-1:0]));
        check_val("valid_in_respond", 64'(reg_valid), 64'd0);
      end else if (reg_valid) begin
        check_val("reg_write", 64'(reg_write), 64'(wr));
        check_val("reg_address", 64'(reg_address), 64'(exp_addr));
        check_val("reg_wdata", 64'(reg_write_data), 64'(exp_wdata));
        check_val("reg_wmask", 64'(reg_write_mask), 64'(exp_mask));
        vcyc++;
      end
      if (!got) begin @(posedge clk); #1; end
    end
    if (!got) begin
      check_val("pready_seen", 64'd0, 64'd1);
      void'(exp_q.pop_front());
    end
    check_val("valid_cycles", 64'(vcyc), 64'(exp_vcyc));
    reg_ready = 1'b0;
  endtask

  initial begin
    int r, dly;
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; paddr = '0; pwrite = 1'b0;
    pwdata = '0; pstrb = '0; reg_ready = 1'b0; reg_read_data = '0; reg_status = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // directed cases
    apb_xfer(16'h0008, 1'b1, 32'hA5A5_1234, 4'b0011, 0, 32'h0, 2'b00);
    apb_xfer(16'h0010, 1'b0, 32'h0, 4'b0000, 3, 32'hDEAD_BEEF, 2'b00);
    apb_xfer(16'h0200, 1'b0, 32'h0, 4'b0000, 0, 32'h1111_2222, 2'b00);
    apb_xfer(16'h0004, 1'b0, 32'h0, 4'b0000, 100, 32'h3333_4444, 2'b00);
    apb_xfer(16'h0004, 1'b0, 32'h0, 4'b0000, TIMEOUT - 1, 32'h5555_6666, 2'b00);
    apb_xfer(16'h0020, 1'b1, 32'hFFFF_FFFF, 4'b0000, 0, 32'h0, 2'b00);
    apb_xfer(16'h0024, 1'b1, 32'h1234_5678, 4'b1100, 1, 32'h0, 2'b10);
    apb_xfer(16'h0013, 1'b0, 32'h0, 4'b0000, 0, 32'hCAFE_F00D, 2'b01);
    apb_xfer(16'h0014, 1'b0, 32'h0, 4'b0000, 2, 32'hCAFE_F00D, 2'b11);
    apb_xfer(16'h00FF, 1'b1, 32'h8765_4321, 4'b1000, 0, 32'h0, 2'b00);
    idle_cycles(2);

    // reset during ACCESS
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; paddr = 16'h0030; pwrite = 1'b1; pwdata = 32'h0BAD_0BAD; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1; reg_ready = 1'b0;
    @(negedge clk);
    check_val("pre_reset_valid", 64'(reg_valid), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_quiet("async_reset");
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    rst_n = 1'b1;
    idle_cycles(3);
    apb_xfer(16'h0040, 1'b0, 32'h0, 4'b0000, 0, 32'h0F0F_0F0F, 2'b00);

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      if (r < 7) dly = $urandom_range(0, 4);
      else if (r == 7) dly = TIMEOUT - 1;
      else if (r == 8) dly = TIMEOUT;
      else dly = TIMEOUT + 4;
      apb_xfer(AW'($urandom_range(0, 511)), 1'($urandom_range(0, 1)), $urandom,
               4'($urandom_range(0, 15)), dly, $urandom, 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
    end

    check_val("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
